// File: rtl/predictor_saltos.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// carrying each fetch-time prediction F->D->E and training on E-stage resolution.
module predictor_saltos #(
  parameter int ENTRADAS = 16,
  parameter int ANCHO_PC = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [ANCHO_PC-1:0] PCF_i,
  input  logic                StallD_i,
  input  logic                FlushD_i,
  input  logic                FlushE_i,
  input  logic [ANCHO_PC-1:0] PCE_i,
  input  logic                BranchE_i,
  input  logic                JumpE_i,
  input  logic                PCSrcE_i,
  input  logic [ANCHO_PC-1:0] PCTargetE_i,
  output logic                prediccion_F_o,
  output logic [ANCHO_PC-1:0] PC_predicho_F_o,
  output logic                bp_activo_o,
  output logic                fallo_tomado_o,
  output logic [ANCHO_PC-1:0] PC_correcto_o
);
  localparam int IDX   = $clog2(ENTRADAS);
  localparam int TAG_W = ANCHO_PC - IDX - 2;
  localparam logic [ANCHO_PC-1:0] CUATRO = ANCHO_PC'(4);

  logic                valid_q [ENTRADAS];
  logic [1:0]          cnt_q   [ENTRADAS];
  logic [TAG_W-1:0]    tag_q   [ENTRADAS];
  logic [ANCHO_PC-1:0] tgt_q   [ENTRADAS];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // F stage: combinational lookup
  logic [IDX-1:0]      idx_p0;
  logic [TAG_W-1:0]    tag_p0;
  logic                hit_p0;
  logic                pred_p0;
  logic [ANCHO_PC-1:0] pc_pred_p0;

  assign idx_p0     = PCF_i[IDX+1:2];
  assign tag_p0     = PCF_i[ANCHO_PC-1:IDX+2];
  assign hit_p0     = valid_q[idx_p0] && (tag_q[idx_p0] == tag_p0);
  assign pred_p0    = hit_p0 & cnt_q[idx_p0][1];
  assign pc_pred_p0 = pred_p0 ? tgt_q[idx_p0] : PCF_i + CUATRO;

  assign prediccion_F_o  = pred_p0;
  assign PC_predicho_F_o = pc_pred_p0;

  // F->D boundary: flush wins over stall
  logic                pred_p1;
  logic [ANCHO_PC-1:0] tgt_p1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pred_p1 <= 1'b0;
      tgt_p1  <= '0;
    end else if (FlushD_i) begin
      pred_p1 <= 1'b0;
      tgt_p1  <= '0;
    end else if (!StallD_i) begin
      pred_p1 <= pred_p0;
      tgt_p1  <= pc_pred_p0;
    end
  end

  // D->E boundary
  logic                pred_p2;
  logic [ANCHO_PC-1:0] tgt_p2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pred_p2 <= 1'b0;
      tgt_p2  <= '0;
    end else if (FlushE_i) begin
      pred_p2 <= 1'b0;
      tgt_p2  <= '0;
    end else begin
      pred_p2 <= pred_p1;
      tgt_p2  <= tgt_p1;
    end
  end

  // E stage: compare prediction against resolution
  assign bp_activo_o    = pred_p2 & PCSrcE_i & (tgt_p2 == PCTargetE_i);
  assign fallo_tomado_o = pred_p2 & ~PCSrcE_i;
  assign PC_correcto_o  = PCE_i + CUATRO;

  logic [IDX-1:0]   idx_p2;
  logic [TAG_W-1:0] tag_p2;
  logic             hit_p2;
  logic             taken_p2;
  logic             train_p2;

  assign idx_p2   = PCE_i[IDX+1:2];
  assign tag_p2   = PCE_i[ANCHO_PC-1:IDX+2];
  assign hit_p2   = valid_q[idx_p2] && (tag_q[idx_p2] == tag_p2);
  assign taken_p2 = PCSrcE_i | JumpE_i;
  assign train_p2 = BranchE_i | JumpE_i;

  // Table write at the edge; same-cycle lookups still see the old entry
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRADAS; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (train_p2) begin
      if (hit_p2) begin
        if (taken_p2) begin
          cnt_q[idx_p2] <= sat_inc(cnt_q[idx_p2]);
          tgt_q[idx_p2] <= PCTargetE_i;
        end else begin
          cnt_q[idx_p2] <= sat_dec(cnt_q[idx_p2]);
        end
      end else if (taken_p2) begin
        valid_q[idx_p2] <= 1'b1;
        tag_q[idx_p2]   <= tag_p2;
        tgt_q[idx_p2]   <= PCTargetE_i;
        cnt_q[idx_p2]   <= 2'b10;
      end
    end
  end
endmodule
